inv_sub_bytes_seq: RTL
======================

Name: inv_sub_bytes_seq

Overview:
Applies the AES inverse S-box (InvSubBytes) to a full 128-bit AES state. It is the decryption-side counterpart of the forward byte substitution.
The block iterates over the 16 state bytes, LANES bytes per cycle, using LANES inverse-S-box lookups. This trades area for latency.
It sits in the AES-128 decryption round datapath between InvShiftRows and AddRoundKey, with valid/ready handshakes on both sides.

Parameters:
LANES, 4, bytes substituted per clock; legal values 1, 2, 4, 8, 16; processing cycles per block = 16/LANES.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a new state
in_data  input  128  input state; byte 0 = [127:120], byte 15 = [7:0]
out_valid  output  1  out_data holds a completed result
out_ready  input  1  downstream accepts out_data
out_data  output  128  substituted state; same byte order as in_data
busy  output  1  high in BUSY state

Behaviour:
- One clock; reset is asynchronous and active-high. On reset assertion, immediately (no clock edge needed):
  - state=IDLE, counter=0, working register=0.
  - in_ready=1, out_valid=0, busy=0, out_data=128'h0.
- InvSBox(y) = x such that SBox(x) = y for the AES forward S-box.
  - Spot values: InvSBox(63)=00, (7c)=01, (00)=52, (ed)=53, (16)=ff, (01)=09.
  - Implemented as a 256-entry combinational table per lane.
- State machine:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into the working register, counter=0, go to BUSY.
  - BUSY: in_ready=0, busy=1.
    - Each cycle, the group of bytes [counter*LANES .. counter*LANES+LANES-1] is replaced by its InvSBox value; other bytes are unchanged.
    - counter increments by 1.
    - After the group with counter = 16/LANES-1, go to DONE.
  - DONE: out_valid=1, and out_data equals the working register, held stable.
    - On out_valid&&out_ready, go to IDLE, out_valid deasserts at that edge, and in_ready=1 the next cycle.
    - out_ready low stalls indefinitely with no data change.
- Latency: accept at edge k; out_valid is high after edge k+16/LANES.
  - LANES=16 gives a single BUSY cycle.
  - No overlap: a new block cannot be accepted in the same cycle a result is consumed. Throughput is one block per 16/LANES+2 cycles at most.
- counter width: clog2(16/LANES), minimum 1 bit. It wraps to 0 on BUSY→DONE.
- in_data and in_valid are ignored outside IDLE. in_valid while busy is not lost by the block: the upstream must hold it per the handshake rule, and it is accepted on return to IDLE.
- out_data in IDLE/BUSY shows the working register; it is only meaningful when out_valid=1.
- Reset asserted mid-BUSY or in DONE aborts the block: the result is discarded and all outputs return to their reset values.
- A LANES value that is not a power of two dividing 16 is illegal; the build fails via elaboration-time check.

Test Plan:
- Reset, LANES=4: assert reset asynchronously between edges. Required: in_ready=1, out_valid=0, busy=0, out_data=0 immediately. Release reset, then idle 5 cycles → no change.
- LANES=4, in_data=000102030405060708090a0b0c0d0e0f, out_ready=1:
  - Required: out_valid exactly 4 edges after accept.
  - Required: out_data=52096ad53036a538bf40a39e81f3d7fb.
- LANES=1, in_data=all bytes 63: required out_data=all 00 after exactly 16 edges. LANES=16 with the same input: required out_data=all 00 after 1 edge.
- Backpressure, LANES=4:
  - Hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, out_data is stable, in_ready=0.
  - A second in_valid held high is accepted only on the cycle after out_ready=1 handshake.
- Reset mid-op: accept a block, assert reset after 2 BUSY cycles. Required: out_valid never rises, busy=0. A fresh block 000102…0f then returns the correct result.
- Roundtrip: for all 256 byte values, drive the existing forward S-box output into every byte position. Required: the inverse recovers the original byte in all 16 positions, for LANES 1, 2, 4, 8, 16.

Source files
------------

// File: rtl/inv_sub_bytes_seq.sv
// AES InvSubBytes over a 128-bit state, LANES bytes per clock, with valid/ready
// handshakes on both sides. Byte 0 sits in [127:120], byte 15 in [7:0].
module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int STEPS     = 16 / LANES;
    localparam int CW        = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int LAST_BYTE = 15;
    localparam int BYTE_W    = 8;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    // Inverse S-box, entry 0 in the top byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{8'hff - b, 3'b000} +: 8];
    endfunction

    function automatic int byte_lsb(input int idx);
        return (LAST_BYTE - idx) * BYTE_W;
    endfunction

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t          state_r, state_nx_s;
    logic [CW-1:0]   cnt_r, cnt_nx_s;
    logic [127:0]    work_r, work_nx_s, sub_work_s;
    logic            in_ready_r, out_valid_r, busy_r;

    // Substitute the current lane group; only LANES lookups exist.
    always_comb begin
        sub_work_s = work_r;
        for (int l = 0; l < LANES; l++) begin
            sub_work_s[byte_lsb(int'(cnt_r) * LANES + l) +: 8] =
                inv_sbox(work_r[byte_lsb(int'(cnt_r) * LANES + l) +: 8]);
        end
    end

    // Next-state, counter and working-register update.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        work_nx_s  = work_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    work_nx_s  = in_data;
                    cnt_nx_s   = {CW{1'b0}};
                    state_nx_s = BUSY;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY: begin
                work_nx_s = sub_work_s;
                if (cnt_r == LAST_STEP) begin
                    cnt_nx_s   = {CW{1'b0}};
                    state_nx_s = DONE;
                end else begin
                    cnt_nx_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            work_r      <= 128'h0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            work_r      <= work_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
            busy_r      <= (state_nx_s == BUSY);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = work_r;

endmodule
